// File: rtl/riscv_pkg.sv
// Shared constants for the integer register file and its pending-write scoreboard.
package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int REG_ADDR_W   = 5;
  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register plus a running count of set bits.
module regfile_scoreboard
  import riscv_pkg::*;
#(
  parameter int NREGS = 32,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [AW-1:0]    set_addr,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_addr,
  output logic [NREGS-1:0] pend,
  output logic [AW:0]      pend_cnt
);

  logic [NREGS-1:0] pend_q, pend_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             set_hit, clr_hit, inc, dec;

  always_comb begin
    set_hit = set_en && (set_addr != AW'(REG_ZERO));
    clr_hit = clr_en && (clr_addr != AW'(REG_ZERO));

    // Set is applied after clear so a same-register collision leaves the bit owned by the new issue.
    pend_d = pend_q;
    if (clr_hit) pend_d[clr_addr] = 1'b0;
    if (set_hit) pend_d[set_addr] = 1'b1;

    inc   = set_hit && !pend_q[set_addr];
    dec   = clr_hit && pend_q[clr_addr] && !(set_hit && (set_addr == clr_addr));
    cnt_d = cnt_q + (AW+1)'(inc) - (AW+1)'(dec);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend     = pend_q;
  assign pend_cnt = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Register file with x0 hardwired to zero and a per-register pending-write scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_SB_BYPASS_EN.
module regfile_sb
  import riscv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int NREGS = 32,
  localparam int AW = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] rs2,
  input  logic            regwrite,
  input  logic [AW-1:0]   writereg_addr,
  input  logic [XLEN-1:0] writedata,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic [AW:0]     pend_cnt
);

  // issue_valid and regwrite are single-cycle strobes with no back-pressure;
  // each is acted on at every rising edge where it is high.
  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] pend;
  logic             wr_en;
  logic             rs1_nz, rs2_nz;
  logic [XLEN-1:0]  rs1_stored, rs2_stored;

  assign wr_en  = regwrite && (writereg_addr != AW'(REG_ZERO));
  assign rs1_nz = (rs1_addr != AW'(REG_ZERO));
  assign rs2_nz = (rs2_addr != AW'(REG_ZERO));

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[writereg_addr] = writedata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  regfile_scoreboard #(.NREGS(NREGS)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (issue_valid),
    .set_addr (issue_rd),
    .clr_en   (regwrite),
    .clr_addr (writereg_addr),
    .pend     (pend),
    .pend_cnt (pend_cnt)
  );

  assign rs1_stored = rs1_nz ? regs_q[rs1_addr] : '0;
  assign rs2_stored = rs2_nz ? regs_q[rs2_addr] : '0;

`ifdef REGFILE_SB_BYPASS_EN
  logic wr_hit1, wr_hit2;

  assign wr_hit1  = wr_en && (writereg_addr == rs1_addr);
  assign wr_hit2  = wr_en && (writereg_addr == rs2_addr);
  assign rs1      = wr_hit1 ? writedata : rs1_stored;
  assign rs2      = wr_hit2 ? writedata : rs2_stored;
  assign rs1_busy = pend[rs1_addr] && rs1_nz && !wr_hit1;
  assign rs2_busy = pend[rs2_addr] && rs2_nz && !wr_hit2;
`else
  // The pending bit stays set through the writeback cycle, so a reader stalls one extra cycle.
  assign rs1      = rs1_stored;
  assign rs2      = rs2_stored;
  assign rs1_busy = pend[rs1_addr] && rs1_nz;
  assign rs2_busy = pend[rs2_addr] && rs2_nz;
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: expectations are queued as stimulus is driven and popped at each check.
module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            clk;
  logic            rst;
  logic [AW-1:0]   rs1_addr, rs2_addr, writereg_addr, issue_rd;
  logic [XLEN-1:0] rs1, rs2, writedata;
  logic            regwrite, issue_valid, rs1_busy, rs2_busy;
  logic [AW:0]     pend_cnt;

  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] mdl [32];
  int total = 0;
  int bad   = 0;

  regfile_sb dut (
    .clk           (clk),
    .rst           (rst),
    .rs1_addr      (rs1_addr),
    .rs2_addr      (rs2_addr),
    .rs1           (rs1),
    .rs2           (rs2),
    .regwrite      (regwrite),
    .writereg_addr (writereg_addr),
    .writedata     (writedata),
    .issue_valid   (issue_valid),
    .issue_rd      (issue_rd),
    .rs1_busy      (rs1_busy),
    .rs2_busy      (rs2_busy),
    .pend_cnt      (pend_cnt)
  );

  // Clock and reset: rising edges at 5, 15, ...; inputs change just after falling edges.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input logic [XLEN-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [XLEN-1:0] obs);
    logic [XLEN-1:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s: no expected value queued, observed=%h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  task automatic idle();
    regwrite      = 1'b0;
    writereg_addr = '0;
    writedata     = '0;
    issue_valid   = 1'b0;
    issue_rd      = '0;
  endtask

  // Drives one cycle of writeback/issue and updates the reference register model.
  task automatic drv(input logic rw, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                     input logic iv, input logic [AW-1:0] ir);
    regwrite      = rw;
    writereg_addr = wa;
    writedata     = wd;
    issue_valid   = iv;
    issue_rd      = ir;
    if (rw && wa != 0) mdl[wa] = wd;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    idle();
  endtask

  initial begin
    logic [XLEN-1:0] old9, rnd;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    idle();
    rs1_addr = '0;
    rs2_addr = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;

    // Reset state: every address reads zero on both ports.
    for (int i = 0; i < 32; i++) begin
      rs1_addr = AW'(i);
      rs2_addr = AW'(31 - i);
      #0.1;
      push('0); check("rst_rs1", rs1);
      push('0); check("rst_rs2", rs2);
    end
    push('0); check("rst_cnt", 32'(pend_cnt));
    push('0); check("rst_busy1", 32'(rs1_busy));
    push('0); check("rst_busy2", 32'(rs2_busy));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Write x5 and issue x6, then pulse reset between edges.
    drv(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd6);
    rs1_addr = 5'd5;
    rs2_addr = 5'd6;
    next_cycle();
    #1;
    push(32'hDEADBEEF); check("x5_wr", rs1);
    push(32'd1);        check("x6_busy", 32'(rs2_busy));
    push(32'd1);        check("cnt_pre_rst", 32'(pend_cnt));
    rst = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    push(mdl[5]); check("x5_async_rst", rs1);
    push('0);     check("cnt_async_rst", 32'(pend_cnt));
    push('0);     check("busy_async_rst", 32'(rs2_busy));
    #2 rst = 1'b1;

    // Writes to x0 are dropped; x7 is visible the following cycle.
    next_cycle();
    drv(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0);
    next_cycle();
    drv(1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0);
    rs1_addr = 5'd0;
    rs2_addr = 5'd7;
    #1;
    push('0); check("x7_before", rs2);
    next_cycle();
    #1;
    push('0);     check("x0_read", rs1);
    push(mdl[7]); check("x7_read", rs2);
    push('0);     check("cnt_clr_nonpend", 32'(pend_cnt));

    // Issue x3, retire it two cycles later.
    next_cycle();
    drv(1'b0, 5'd0, '0, 1'b1, 5'd3);
    rs1_addr = 5'd3;
    next_cycle();
    #1;
    push(32'd1); check("x3_busy", 32'(rs1_busy));
    push(32'd1); check("x3_cnt", 32'(pend_cnt));
    next_cycle();
    drv(1'b1, 5'd3, 32'hA5, 1'b0, 5'd0);
    #1;
`ifdef REGFILE_SB_BYPASS_EN
    push(32'd0);  check("x3_wb_busy", 32'(rs1_busy));
    push(32'hA5); check("x3_wb_data", rs1);
`else
    push(32'd1);  check("x3_wb_busy", 32'(rs1_busy));
    push(32'h0);  check("x3_wb_data", rs1);
`endif
    next_cycle();
    #1;
    push(32'd0);  check("x3_ret_busy", 32'(rs1_busy));
    push(mdl[3]); check("x3_ret_data", rs1);
    push(32'd0);  check("x3_ret_cnt", 32'(pend_cnt));

    // Same-register set and clear in one cycle: stays pending, count unchanged, data written.
    next_cycle();
    drv(1'b0, 5'd0, '0, 1'b1, 5'd4);
    rs1_addr = 5'd4;
    next_cycle();
    drv(1'b1, 5'd4, 32'h11, 1'b1, 5'd4);
    next_cycle();
    #1;
    push(32'd1);  check("col_busy", 32'(rs1_busy));
    push(32'd1);  check("col_cnt", 32'(pend_cnt));
    push(mdl[4]); check("col_data", rs1);

    // Set of x10 with clear of x4 in one cycle nets zero; then clear x10.
    next_cycle();
    drv(1'b1, 5'd4, 32'h22, 1'b1, 5'd10);
    next_cycle();
    #1;
    push(32'd1); check("net0_cnt", 32'(pend_cnt));
    push(32'd0); check("net0_x4_busy", 32'(rs1_busy));
    drv(1'b1, 5'd10, 32'h10, 1'b0, 5'd0);
    next_cycle();
    #1;
    push(32'd0); check("net0_ret_cnt", 32'(pend_cnt));

    // Bypass behaviour on rs2 with x9 pending and an older stored value.
    drv(1'b1, 5'd9, 32'h33, 1'b1, 5'd9);
    next_cycle();
    old9 = mdl[9];
    rs2_addr = 5'd9;
    drv(1'b1, 5'd9, 32'h55, 1'b0, 5'd0);
    #1;
`ifdef REGFILE_SB_BYPASS_EN
    push(32'h55); check("byp_rs2", rs2);
    push(32'd0);  check("byp_busy", 32'(rs2_busy));
`else
    push(old9);   check("byp_rs2", rs2);
    push(32'd1);  check("byp_busy", 32'(rs2_busy));
`endif
    next_cycle();
    #1;
    push(mdl[9]); check("byp_after", rs2);
    push(32'd0);  check("byp_cnt", 32'(pend_cnt));

    // Fill the scoreboard, poke x0 and a duplicate issue, then retire everything.
    for (int r = 1; r < 32; r++) begin
      drv(1'b0, 5'd0, '0, 1'b1, AW'(r));
      next_cycle();
    end
    #1;
    push(32'd31); check("fill_cnt", 32'(pend_cnt));
    rs2_addr = 5'd31;
    #1;
    push(32'd1);  check("fill_busy31", 32'(rs2_busy));
    drv(1'b0, 5'd0, '0, 1'b1, 5'd0);
    next_cycle();
    drv(1'b0, 5'd0, '0, 1'b1, 5'd5);
    next_cycle();
    #1;
    push(32'd31); check("fill_x0_dup_cnt", 32'(pend_cnt));
    for (int r = 1; r < 32; r++) begin
      rnd = $urandom_range(32'hFFFF_FFFF, 0);
      drv(1'b1, AW'(r), rnd, 1'b0, 5'd0);
      next_cycle();
      if (r == 16) begin
        #1;
        push(32'd15); check("drain_half_cnt", 32'(pend_cnt));
      end
    end
    #1;
    push(32'd0); check("drain_cnt", 32'(pend_cnt));
    for (int k = 0; k < 4; k++) begin
      rs1_addr = AW'($urandom_range(31, 1));
      rs2_addr = AW'($urandom_range(31, 0));
      #1;
      push(mdl[rs1_addr]); check("drain_rd1", rs1);
      push(mdl[rs2_addr]); check("drain_rd2", rs2);
    end

    if (exp_q.size() != 0) begin
      bad++;
      $error("FAIL leftover: observed=%0d queued expectations, expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
